// File: rtl/bin_oh_pkg.sv
// Shared types and the binary-to-one-hot encoder used by the streaming converter.
package bin_oh_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    SWEEP  = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  // Widest one-hot the encoder can build; callers slice the low OUT_W bits.
  localparam int unsigned MAX_OUT_W = 256;

  // Returns {err, one_hot}; err sits in the top bit so any OUT_W can extract it.
  function automatic logic [MAX_OUT_W:0] bin2oh(input logic [31:0] code,
                                                input logic [31:0] out_w);
    logic [MAX_OUT_W:0] res;
    if (code < out_w) begin
      res = {{MAX_OUT_W{1'b0}}, 1'b1} << code;
    end else begin
      res = {1'b1, {MAX_OUT_W{1'b0}}};
    end
    return res;
  endfunction

endpackage

// File: rtl/oh_skid_buf.sv
// Two-entry valid/ready FIFO; the head entry is a register and ready never depends on pop_ready_i.
module oh_skid_buf #(
  parameter int unsigned W = 17
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_valid_i,
  output logic         push_ready_o,
  input  logic [W-1:0] push_data_i,
  output logic         pop_valid_o,
  input  logic         pop_ready_i,
  output logic [W-1:0] pop_data_o
);

  logic [1:0]   count_q, count_d;
  logic [W-1:0] e0_q, e0_d;
  logic [W-1:0] e1_q, e1_d;
  logic         ready_q;
  logic         valid_q;
  logic         push_s;
  logic         pop_s;

  // Next occupancy and entry contents; e0 is always the head.
  always_comb begin
    push_s  = push_valid_i & ready_q;
    pop_s   = (count_q != 2'd0) & pop_ready_i;
    count_d = count_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    case (count_q)
      2'd0: begin
        if (push_s) begin
          e0_d    = push_data_i;
          count_d = 2'd1;
        end else begin
          count_d = 2'd0;
        end
      end
      2'd1: begin
        if (push_s && pop_s) begin
          e0_d = push_data_i;
        end else if (push_s) begin
          e1_d    = push_data_i;
          count_d = 2'd2;
        end else if (pop_s) begin
          count_d = 2'd0;
        end else begin
          count_d = 2'd1;
        end
      end
      2'd2: begin
        if (pop_s) begin
          e0_d    = e1_q;
          count_d = 2'd1;
        end else begin
          count_d = 2'd2;
        end
      end
      default: begin
        count_d = 2'd0;
      end
    endcase
  end

  // Storage plus registered ready/valid flags derived from next occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= 2'd0;
      e0_q    <= '0;
      e1_q    <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      ready_q <= (count_d != 2'd2);
      valid_q <= (count_d != 2'd0);
    end
  end

  assign push_ready_o = ready_q;
  assign pop_valid_o  = valid_q;
  assign pop_data_o   = e0_q;

endmodule

// File: rtl/bin_to_one_hot_stream.sv
// Streaming binary-to-one-hot converter with a self-test sweep mode.
module bin_to_one_hot_stream
  import bin_oh_pkg::*;
#(
  parameter int unsigned BIN_W = 4,
  parameter int unsigned OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic             stop,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BIN_W-1:0] in_bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_one_hot,
  output logic             out_err,
  output logic             busy,
  output logic             done
);

  localparam logic [BIN_W-1:0] LAST_CODE = BIN_W'(OUT_W - 1);

  state_t             state_q;
  logic [BIN_W-1:0]   cnt_q;
  logic               done_q;
  logic               push_s;
  logic [BIN_W-1:0]   code_s;
  logic [MAX_OUT_W:0] enc_s;
  logic [OUT_W:0]     entry_s;
  logic [OUT_W:0]     head_s;
  logic               buf_ready_s;
  logic               buf_valid_s;
  logic               unused_enc_s;

  // Source mux: external codes in STREAM, the sweep counter in SWEEP. A stop aborts the sweep push.
  always_comb begin
    push_s = 1'b0;
    code_s = in_bin;
    case (state_q)
      STREAM: begin
        push_s = in_valid & buf_ready_s;
        code_s = in_bin;
      end
      SWEEP: begin
        push_s = buf_ready_s & ~stop;
        code_s = cnt_q;
      end
      default: begin
        push_s = 1'b0;
        code_s = in_bin;
      end
    endcase
  end

  assign enc_s        = bin2oh(32'(code_s), 32'(OUT_W));
  assign entry_s      = {enc_s[MAX_OUT_W], enc_s[OUT_W-1:0]};
  assign unused_enc_s = ^enc_s;

  // Control FSM with the sweep counter and the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= mode ? SWEEP : STREAM;
            cnt_q   <= '0;
          end
        end
        STREAM: begin
          if (stop) begin
            state_q <= DRAIN;
          end
        end
        SWEEP: begin
          if (stop) begin
            state_q <= DRAIN;
          end else if (push_s) begin
            if (cnt_q == LAST_CODE) begin
              state_q <= DRAIN;
            end else begin
              cnt_q <= cnt_q + BIN_W'(1);
            end
          end
        end
        DRAIN: begin
          if (!buf_valid_s) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  oh_skid_buf #(
    .W(OUT_W + 1)
  ) u_buf (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_valid_i(push_s),
    .push_ready_o(buf_ready_s),
    .push_data_i (entry_s),
    .pop_valid_o (buf_valid_s),
    .pop_ready_i (out_ready),
    .pop_data_o  (head_s)
  );

  assign in_ready    = (state_q == STREAM) & buf_ready_s;
  assign out_valid   = buf_valid_s;
  assign out_one_hot = head_s[OUT_W-1:0];
  assign out_err     = head_s[OUT_W];
  assign busy        = (state_q != IDLE);
  assign done        = done_q;

endmodule
